// File: rtl/rr_enc_arbiter_8_pkg.sv
// Shared constants for the 8-way round-robin arbiter and its priority encoders.
// FSM state codes are fixed values so debug probes and benches can compare against them.
package rr_enc_arbiter_8_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef logic state_t;

  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_BUSY = 1'b1;

endpackage

// File: rtl/pri_enc_8_to_3.sv
// 8-to-3 priority encoder: the highest set bit wins, vld=0 when the input is all zero.
module pri_enc_8_to_3
  import rr_enc_arbiter_8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
    idx = '0;
    vld = 1'b0;
    // Ascending scan: a later (higher) set bit overwrites an earlier one.
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) begin
        idx = IDX_W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_enc_arbiter_8.sv
// Round-robin arbiter for 8 requesters with a registered one-hot grant and a capped hold time.
// A masked and a raw priority encoder together give rotating descending-index priority.
module rr_enc_arbiter_8
  import rr_enc_arbiter_8_pkg::*;
#(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   last_idx;
  logic [CNT_W-1:0]   hold_cnt;

  logic [N_REQ-1:0]   mask;
  logic [IDX_W-1:0]   m_idx;
  logic               m_vld;
  logic [IDX_W-1:0]   r_idx;
  logic               r_vld;
  logic [IDX_W-1:0]   win_idx;
  logic               win_vld;
  logic               keep;

  logic [N_REQ-1:0]   gnt_nxt;
  logic [IDX_W-1:0]   gnt_idx_nxt;
  logic               gnt_vld_nxt;
  logic [IDX_W-1:0]   last_idx_nxt;
  logic [CNT_W-1:0]   hold_cnt_nxt;

  // Only indices below the last winner stay eligible in the masked search.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mask[i] = (IDX_W'(i) < last_idx);
    end
  end

  pri_enc_8_to_3 u_enc_masked (
    .req (req & mask),
    .idx (m_idx),
    .vld (m_vld)
  );

  pri_enc_8_to_3 u_enc_raw (
    .req (req),
    .idx (r_idx),
    .vld (r_vld)
  );

  assign win_vld = m_vld | r_vld;
  assign win_idx = m_vld ? m_idx : r_idx;

  // While busy, last_idx equals gnt_idx, so the mask above is already built from the holder.
  assign keep = (state == ST_BUSY) && req[gnt_idx] && (hold_cnt < CNT_W'(HOLD_MAX));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (win_vld) state_nxt = ST_BUSY;
      ST_BUSY: if (!keep && !win_vld) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values for the registered grant, rotation pointer and hold counter.
  always_comb begin
    gnt_nxt      = gnt;
    gnt_idx_nxt  = gnt_idx;
    gnt_vld_nxt  = gnt_vld;
    last_idx_nxt = last_idx;
    hold_cnt_nxt = hold_cnt;
    if (keep) begin
      hold_cnt_nxt = hold_cnt + CNT_W'(1);
    end else if (win_vld) begin
      // Release or expiry hands over without a bubble; a lone holder is simply reselected.
      gnt_nxt      = N_REQ'(1) << win_idx;
      gnt_idx_nxt  = win_idx;
      gnt_vld_nxt  = 1'b1;
      last_idx_nxt = win_idx;
      hold_cnt_nxt = CNT_W'(1);
    end else begin
      gnt_nxt      = '0;
      gnt_idx_nxt  = '0;
      gnt_vld_nxt  = 1'b0;
      hold_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      gnt_idx  <= '0;
      gnt_vld  <= 1'b0;
      last_idx <= '0;
      hold_cnt <= '0;
    end else begin
      gnt      <= gnt_nxt;
      gnt_idx  <= gnt_idx_nxt;
      gnt_vld  <= gnt_vld_nxt;
      last_idx <= last_idx_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_rr_enc_arbiter_8.sv
// Bench for rr_enc_arbiter_8: two instances (HOLD_MAX=4 and HOLD_MAX=1) checked every cycle
// against a rotating-priority model, plus directed literal expectations.
module tb_rr_enc_arbiter_8;
  import rr_enc_arbiter_8_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;

  logic [7:0] g4, g1;
  logic [2:0] i4, i1;
  logic       v4, v1;

  int checks = 0;
  int errors = 0;

  rr_enc_arbiter_8 #(.HOLD_MAX(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(g4), .gnt_idx(i4), .gnt_vld(v4)
  );

  rr_enc_arbiter_8 #(.HOLD_MAX(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(g1), .gnt_idx(i1), .gnt_vld(v1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: holder (-1 = none), consecutive cycles held, last winner.
  typedef struct {
    int holder;
    int cnt;
    int last;
  } mdl_t;

  mdl_t m[2];
  int   hmax[2] = '{4, 1};

  function automatic mdl_t step(input mdl_t s, input logic [7:0] r, input int hm);
    mdl_t n = s;
    int   found = -1;
    if (s.holder >= 0 && r[s.holder] && s.cnt < hm) begin
      n.cnt = s.cnt + 1;
      return n;
    end
    // After granting k, priority is k-1, k-2, ..., 0, 7, ..., k.
    for (int j = 1; j <= 8; j++) begin
      int c = (s.last - j + 8) % 8;
      if (found < 0 && r[c]) found = c;
    end
    if (found >= 0) begin
      n.holder = found;
      n.last   = found;
      n.cnt    = 1;
    end else begin
      n.holder = -1;
      n.cnt    = 0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 2; j++) begin
        m[j].holder = -1;
        m[j].cnt    = 0;
        m[j].last   = 0;
      end
    end else begin
      for (int j = 0; j < 2; j++) m[j] = step(m[j], req, hmax[j]);
    end
  end

  task automatic cmp(input string tag, input mdl_t s, input logic [7:0] g, input logic [2:0] ix,
                     input logic v, input logic [7:0] cnt);
    logic [7:0] eg;
    eg = (s.holder >= 0) ? (8'd1 << s.holder) : 8'd0;
    check({tag, "_gnt"}, g, eg);
    check({tag, "_idx"}, ix, (s.holder >= 0) ? s.holder : 0);
    check({tag, "_vld"}, v, (s.holder >= 0) ? 1 : 0);
    check({tag, "_cnt"}, cnt, s.cnt);
    check({tag, "_onehot"}, g, {7'd0, v} << ix);
  endtask

  always @(negedge clk) begin
    cmp("m4", m[0], g4, i4, v4, dut.hold_cnt);
    cmp("m1", m[1], g1, i1, v1, dut1.hold_cnt);
  end

  int exp_rot1[9]  = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
  int exp_rot4[9]  = '{7, 7, 7, 7, 6, 6, 6, 6, 5};
  int exp_cnt[10]  = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 2};
  int exp_fair[9]  = '{7, 7, 7, 7, 0, 0, 0, 0, 7};
  logic [7:0] vec[20] = '{8'hFF, 8'hFF, 8'h0F, 8'hF0, 8'h01, 8'h00, 8'h80, 8'hC3, 8'h3C, 8'h3C,
                          8'h18, 8'h00, 8'hAA, 8'h55, 8'hFF, 8'h81, 8'h81, 8'h00, 8'h02, 8'h40};

  initial begin
    // Reset with every line requesting
    rst_n = 1'b0;
    req   = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_gnt", g4, 8'h00);
    check("rst_idx", i4, 3'd0);
    check("rst_vld", v4, 1'b0);
    rst_n = 1'b1;

    // Full load: per-cycle rotation at HOLD_MAX=1, four-cycle slices at HOLD_MAX=4
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 0) check("first_gnt", g4, 8'h80);
      check("rot_h1_idx", i1, exp_rot1[k]);
      check("rot_h4_idx", i4, exp_rot4[k]);
    end
    req = 8'h00;
    @(negedge clk);
    check("drop_vld", v4, 1'b0);

    // Single requester: continuous grant, counter wraps at HOLD_MAX
    req = 8'b0000_0100;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("single_gnt", g4, 8'h04);
      check("single_cnt", dut.hold_cnt, exp_cnt[k]);
    end

    // Expiry fairness between 7 and 0 after a fresh reset
    req   = 8'h00;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req   = 8'b1000_0001;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("fair_idx", i4, exp_fair[k]);
      check("fair_vld", v4, 1'b1);
    end

    // Early release of idx 5 hands over to idx 2, then everything drops
    req = 8'h00;
    repeat (2) @(negedge clk);
    req = 8'b0010_0100;
    @(negedge clk);
    check("early_first", g4, 8'h20);
    @(negedge clk);
    check("early_second", g4, 8'h20);
    req = 8'b0000_0100;
    @(negedge clk);
    check("early_handover", g4, 8'h04);
    req = 8'h00;
    @(negedge clk);
    check("early_clear_gnt", g4, 8'h00);
    check("early_clear_vld", v4, 1'b0);
    check("early_state", dut.state, ST_IDLE);

    // Asynchronous reset while idx 4 is granted
    req = 8'h10;
    @(negedge clk);
    check("async_pre", g4, 8'h10);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_gnt", g4, 8'h00);
    check("async_vld", v4, 1'b0);
    req = 8'h11;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("async_restart_idx", i4, 3'd4);
    check("async_restart_gnt", g4, 8'h10);

    // Mixed traffic: mid-hold arrivals, simultaneous release and new requests
    for (int k = 0; k < 20; k++) begin
      req = vec[k];
      @(negedge clk);
    end
    req = 8'h00;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
